// File: rtl/mips32_mem_dump_reader.sv
// Streams a contiguous, wrapping range of data-memory words out over valid/ready after a halt.
// Optional DUMP_CHECKSUM_EN adds a running sum (csum) of all accepted words.
module mips32_mem_dump_reader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              halted,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic              done_q, err_q;
    logic              rd_en, room, push, pop, accept;

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;

    // Reserve a FIFO slot for the read still in flight so a stalled consumer never overflows us.
    assign room   = ({1'b0, count_q} + {{(PtrW + 1){1'b0}}, inflight_q}) < (PtrW + 2)'(FIFO_DEPTH);
    assign accept = (state_q == StIdle) && start && halted;
    assign push   = inflight_q;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = base_addr;
                    rem_d   = word_cnt;
                    state_d = (word_cnt == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (room) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W + 1)'(1);
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q && (count_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= rd_en;
            inflight_addr_q <= addr_q;
            done_q          <= (state_q == StDone);
            err_q           <= start && !((state_q == StIdle) && halted);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: outputs are gated by out_valid and the pointers are reset.
    always_ff @(posedge clk1) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rd_data;
            fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        end
    end

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_en ? addr_q : '0;
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_addr    = out_valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign busy        = (state_q == StRead) || (state_q == StDrain);
    assign done        = done_q;
    assign err         = err_q;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + out_data;
        end
    end

    assign csum = csum_q;
`endif

endmodule
